// File: rtl/ls_serial_rx4.sv
// Serial-in/parallel-out receiver: collects WIDTH bits MSB-first into a holding
// register with a ready/ack handshake, sticky overrun flag and tri-state output.
module ls_serial_rx4 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync,
  input  logic             shift,
  input  logic             ser,
  input  logic             ack,
  input  logic             oe,
  output logic [WIDTH-1:0] q,
  output logic             rdy,
  output logic             ovr,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rdy_q, rdy_d;
  logic             ovr_q, ovr_d;
  logic             complete;

  // Next-state: sync beats shift; completion beats ack for rdy.
  always_comb begin
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    complete = 1'b0;
    if (sync) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (shift) begin
      sr_d = {sr_q[WIDTH-2:0], ser};
      if (cnt_q == CNT_LAST) begin
        complete = 1'b1;
        hold_d   = sr_d;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    rdy_d = complete ? 1'b1 : (ack ? 1'b0 : rdy_q);
    ovr_d = ovr_q | (complete & rdy_q & ~ack);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      hold_q <= '0;
      rdy_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
      rdy_q  <= rdy_d;
      ovr_q  <= ovr_d;
    end
  end

  assign q    = oe ? hold_q : {WIDTH{1'bz}};
  assign rdy  = rdy_q;
  assign ovr  = ovr_q;
  assign busy = (cnt_q != '0);

endmodule

// File: tb/tb_ls_serial_rx4.sv
// Scoreboard bench for ls_serial_rx4: a bit-queue reference model predicts the
// outputs after each edge; a monitor compares them one clock at a time.
module tb_ls_serial_rx4;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             sync = 1'b0;
  logic             shift = 1'b0;
  logic             ser = 1'b0;
  logic             ack = 1'b0;
  logic             oe = 1'b0;
  wire  [WIDTH-1:0] q;
  logic             rdy, ovr, busy;

  ls_serial_rx4 #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .sync(sync), .shift(shift), .ser(ser),
    .ack(ack), .oe(oe), .q(q), .rdy(rdy), .ovr(ovr), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic             rdy;
    logic             ovr;
    logic             busy;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_pass = 0;
  int    n_total = 0;

  // Reference model: bits received since the last restart, oldest first.
  int               bits_m[$];
  logic [WIDTH-1:0] hold_m = '0;
  logic             rdy_m = 1'b0;
  logic             ovr_m = 1'b0;

  task automatic model_edge(input logic r, s, sh, sd, a);
    int word;
    if (r) begin
      bits_m.delete();
      hold_m = '0;
      rdy_m  = 1'b0;
      ovr_m  = 1'b0;
    end else begin
      if (!s && sh) bits_m.push_back(int'(sd));
      if (!s && sh && bits_m.size() == WIDTH) begin
        word = 0;
        for (int i = 0; i < WIDTH; i++) word = word * 2 + bits_m[i];
        if (rdy_m && !a) ovr_m = 1'b1;
        hold_m = WIDTH'(word);
        rdy_m  = 1'b1;
        bits_m.delete();
      end else if (a) begin
        rdy_m = 1'b0;
      end
      if (s) bits_m.delete();
    end
  endtask

  // Drive one clock of stimulus and queue the outputs expected after it.
  task automatic step(input logic r, s, sh, sd, a, o, input string tag);
    exp_t e;
    rst = r; sync = s; shift = sh; ser = sd; ack = a; oe = o;
    model_edge(r, s, sh, sd, a);
    e.q    = o ? hold_m : {WIDTH{1'bz}};
    e.rdy  = rdy_m;
    e.ovr  = ovr_m;
    e.busy = (bits_m.size() != 0);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [WIDTH-1:0] w, input int gap, input logic ack_last,
                      input string tag);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      step(1'b0, 1'b0, 1'b1, w[i], (i == 0) ? ack_last : 1'b0, oe, tag);
      if (i != 0)
        for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, oe, tag);
    end
  endtask

  // Monitor: compare the DUT against the oldest queued expectation each clock.
  initial begin
    exp_t  e;
    string t;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_total++;
        if (q !== e.q || rdy !== e.rdy || ovr !== e.ovr || busy !== e.busy)
          $display("FAIL %s: got q=%b rdy=%b ovr=%b busy=%b, want q=%b rdy=%b ovr=%b busy=%b",
                   t, q, rdy, ovr, busy, e.q, e.rdy, e.ovr, e.busy);
        else
          n_pass++;
      end
    end
  end

  initial begin
    @(posedge clk);
    #2;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "reset");
    oe = 1'b1;
    send(4'b1011, 0, 1'b0, "recv_1011");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "ack_1011");
    send(4'b0110, 2, 1'b0, "gapped_0110");
    send(4'b1100, 0, 1'b1, "ack_collision_1100");
    send(4'b0001, 0, 1'b0, "overrun_0001");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "ovr_sticky_ack");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "ovr_sticky_idle");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "ovr_clear_rst");
    send(4'b1011, 0, 1'b0, "recv_pre_sync");
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "sync_part1");
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "sync_part2");
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "sync_edge");
    send(4'b0101, 0, 1'b0, "after_sync_0101");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "ack_0101");
    send(4'b1011, 0, 1'b1, "hold_1011");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "oe_off");
    oe = 1'b0;
    send(4'b0011, 0, 1'b0, "hiz_load_0011");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "oe_on_0011");
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "rst_midword_a");
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "rst_midword_b");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "rst_midword_c");
    for (int n = 0; n < 3000; n++)
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) != 0), "random");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "final");
    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ls_serial_rx4.md
# ls_serial_rx4

Serial-in, parallel-out receiver that sits at the far end of a serial link driven by a 4-bit parallel-load/shift-right register. It clocks in WIDTH serial bits and transfers the completed word to a holding register on the same edge. It raises a ready flag, which a ready/acknowledge handshake clears, and presents the word on tri-state outputs. It lets a bench or board model close the loop on the shifter: load, shift out, receive, compare.

## Interface
- WIDTH, 4: word length in bits, and shifts per word (WIDTH ≥ 2).
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, synchronous, active-high.
- sync  input  1  frame restart: clears bit counter and shift register.
- shift  input  1  shift enable; when 1, `ser` is sampled on this edge.
- ser  input  1  serial data in.
- ack  input  1  consumer acknowledge; clears `rdy`.
- oe  input  1  output enable, active-high.
- q  output  WIDTH  holding register when `oe`=1, high-Z when `oe`=0.
- rdy  output  1  completed word waiting in holding register.
- ovr  output  1  sticky overrun flag.
- busy  output  1  partial word in progress (bit counter ≠ 0).

## Operation
- Internal state:
  - shift register `sr[WIDTH-1:0]`;
  - bit counter `cnt`, range 0..WIDTH-1, width clog2(WIDTH);
  - holding register `hold[WIDTH-1:0]`;
  - flags `rdy` and `ovr`.
- Shift direction matches the transmitter: `sr[0]` ← `ser`, `sr[i]` ← `sr[i-1]`. The first bit received ends in bit WIDTH-1, so the received word equals the transmitted parallel word.
- Edge priority:
  - `rst` first;
  - then `sync`;
  - then `shift`;
  - otherwise hold.
- On `rst`:
  - `sr`=0, `cnt`=0, `hold`=0;
  - `rdy`=0, `ovr`=0.
- On `sync`=1 (no `rst`):
  - `sr`=0, `cnt`=0; the bit presented on `ser` is discarded even if `shift`=1.
  - `hold`, `rdy` and `ovr` are unchanged; `ack` still applies.
- On `shift`=1 with `cnt` < WIDTH-1: shift `ser` in, `cnt`+1.
- On `shift`=1 with `cnt`=WIDTH-1 (word completion):
  - `hold` ← {`sr[WIDTH-2:0]`, `ser`}, `cnt` ← 0, `rdy` ← 1;
  - `sr` also takes the shifted value.
- Overrun: completion while `rdy`=1 and `ack`=0 sets `ovr`.
  - `hold` is overwritten; latest word wins.
  - `ovr` clears only on `rst`.
- `ack`=1 with no completion on the same edge: `rdy` ← 0.
- `ack`=1 and completion on the same edge: `rdy` stays 1 (new word), `ovr` not set.
- `ack` while `rdy`=0: no effect.
- `shift`=0: `sr` and `cnt` hold. Any number of idle clocks may separate bits.
- `oe` is purely combinational on `q`. It does not affect internal state; loading and handshake continue while outputs are high-Z.
- `busy` = (`cnt` ≠ 0), combinational from the register.

## Timing
- Latency: word visible on `q` and `rdy`=1 immediately after the edge sampling the WIDTH-th bit. That is WIDTH `shift` edges after the last `sync` or completion.
- `rdy`, `ovr` and `busy` are registered or decoded directly from registers; no combinational path from inputs to them.
- `q` enable/disable follows `oe` with zero clock latency (model delay only).
- Reset mid-word discards the partial word and any held word; the first post-reset bit is bit WIDTH-1.
- Back-to-back words with `shift` held at 1 are supported at one bit per clock with no gap cycle.
- Output values after the first `rst` edge:
  - `q`=0 (if `oe`=1);
  - `rdy`=0, `ovr`=0, `busy`=0.
- Before the first `rst` edge, state is X.

## Test plan
- Reset: apply `rst`=1 for one edge with `oe`=1 → `q`=0000, `rdy`=0, `ovr`=0, `busy`=0.
- Receive word: `shift`=1, `ser` = 1,0,1,1 on four edges →
  - `busy`=1 after the first edge;
  - after the fourth edge, `q`=1011, `rdy`=1, `busy`=0.
  - Then `ack`=1 one edge → `rdy`=0, `q` still 1011.
- Gapped shifting and handshake collision:
  - send 0,1,1,0 with two `shift`=0 clocks between bits → `q`=0110.
  - Next word 1,1,0,0 with `ack`=1 on its completion edge → `q`=1100, `rdy`=1, `ovr`=0.
- Overrun: leave `rdy`=1 unacknowledged, shift in 0,0,0,1 → `q`=0001, `rdy`=1, `ovr`=1.
  - `ovr` stays 1 through `ack`; it clears only after `rst`.
- Sync mid-word: shift 1,1, assert `sync` (with `shift`=1, `ser`=1), then shift 0,1,0,1 →
  - after the `sync` edge, `busy`=0;
  - result `q`=0101; the prior `hold`/`rdy` are unchanged until completion.
- Output enable: with `q`=1011 held, set `oe`=0 → `q`=zzzz.
  - Shift in 0,0,1,1 while disabled, then `oe`=1 → `q`=0011, `rdy`=1.
